// File: rtl/wallace_mult_pipe_if.sv
// Streaming handshake bundle for the pipelined Wallace multiplier: operand side and product side.
interface wallace_mult_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_p;
  logic [TAG_W-1:0]     out_tag;

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_p, out_tag
  );

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_p, out_tag
  );
endinterface

// File: rtl/wallace_mult_pipe.sv
// Pipelined Wallace-tree multiplier WIDTH x WIDTH -> 2*WIDTH with valid/ready and tag passthrough.
// Define WALLACE_SIGNED_EN for two's complement (Baugh-Wooley) operation; unsigned otherwise.
module wallace_mult_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 3,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wallace_mult_pipe_if.slave   s_mul
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned NROWS = WIDTH + 1;

  typedef logic [NROWS-1:0][PW-1:0] rows_t;

  // Rows remaining after lv carry-save levels (3 rows -> 2, leftovers pass through)
  function automatic int unsigned rows_after(int unsigned lv);
    int unsigned n;
    n = NROWS;
    for (int unsigned i = 0; i < lv; i++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction

  function automatic int unsigned count_levels();
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < 64; i++) if (rows_after(i) > 2) c = i + 1;
    return c;
  endfunction

  localparam int unsigned NLEV = count_levels();

  function automatic rows_t csa_level(rows_t x, int unsigned n);
    rows_t       y;
    int unsigned g;
    y = '0;
    g = n / 3;
    for (int unsigned k = 0; k < NROWS / 3; k++) begin
      if (k < g) begin
        y[2*k]   = x[3*k] ^ x[3*k+1] ^ x[3*k+2];
        y[2*k+1] = PW'(((x[3*k] & x[3*k+1]) | (x[3*k] & x[3*k+2]) |
                        (x[3*k+1] & x[3*k+2])) << 1);
      end
    end
    for (int unsigned r = 0; r < 2; r++) begin
      if (r < n % 3) y[2*g+r] = x[3*g+r];
    end
    return y;
  endfunction

  function automatic rows_t cpa(rows_t x);
    rows_t y;
    y    = '0;
    y[0] = x[0] + x[1];
    return y;
  endfunction

  rows_t              w_pp;
  rows_t              w_sout [STAGES];
  rows_t              r_rows [STAGES];
  logic [TAG_W-1:0]   r_tg   [STAGES];
  logic [TAG_W-1:0]   w_tin  [STAGES];
  logic [STAGES-1:0]  r_v;
  logic [STAGES-1:0]  w_vin;
  logic [STAGES-1:0]  w_ld;

  // Partial-product array; the extra row carries the signed correction constant
  always_comb begin
    logic pb;
    w_pp = '0;
    pb   = 1'b0;
    for (int unsigned j = 0; j < WIDTH; j++) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        pb = s_mul.in_a[i] & s_mul.in_b[j];
`ifdef WALLACE_SIGNED_EN
        if ((i == WIDTH - 1) != (j == WIDTH - 1)) pb = ~pb;
`endif
        w_pp[j][i+j] = pb;
      end
    end
`ifdef WALLACE_SIGNED_EN
    w_pp[WIDTH][WIDTH]  = 1'b1;
    w_pp[WIDTH][PW-1]   = 1'b1;
`endif
  end

  // Stage s owns CSA levels [LO,HI); the last stage also does the final carry-propagate add
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int unsigned LO = s * NLEV / STAGES;
    localparam int unsigned HI = (s + 1) * NLEV / STAGES;
    localparam int unsigned NL = HI - LO;

    rows_t lv [NL+1];

    if (s == 0) begin : g_first
      assign lv[0] = w_pp;
    end else begin : g_next
      assign lv[0] = r_rows[s-1];
    end

    for (genvar l = 0; l < NL; l++) begin : g_lv
      assign lv[l+1] = csa_level(lv[l], rows_after(LO + l));
    end

    if (s == STAGES - 1) begin : g_cpa
      assign w_sout[s] = cpa(lv[NL]);
    end else begin : g_mid
      assign w_sout[s] = lv[NL];
    end
  end

  // Load enables ripple back from the output; a stage loads when empty or draining
  always_comb begin
    logic acc;
    w_ld     = '0;
    w_vin    = '0;
    acc      = s_mul.out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      acc     = ~r_v[s] | acc;
      w_ld[s] = acc;
    end
    w_vin[0] = s_mul.in_valid;
    w_tin[0] = s_mul.in_tag;
    for (int unsigned s = 1; s < STAGES; s++) begin
      w_vin[s] = r_v[s-1];
      w_tin[s] = r_tg[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int unsigned s = 0; s < STAGES; s++) begin
        r_rows[s] <= '0;
        r_tg[s]   <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        if (w_ld[s]) begin
          r_v[s] <= w_vin[s];
          if (w_vin[s]) begin
            r_rows[s] <= w_sout[s];
            r_tg[s]   <= w_tin[s];
          end
        end
      end
    end
  end

  assign s_mul.in_ready  = w_ld[0];
  assign s_mul.out_valid = r_v[STAGES-1];
  assign s_mul.out_p     = r_rows[STAGES-1][0];
  assign s_mul.out_tag   = r_tg[STAGES-1];

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Self-checking bench for wallace_mult_pipe (WIDTH=8, STAGES=3, TAG_W=4): directed table,
// latency, backpressure, reset mid-flight and a random-handshake stream against a scoreboard.
module tb_wallace_mult_pipe;
  localparam int unsigned W  = 8;
  localparam int unsigned S  = 3;
  localparam int unsigned TW = 4;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  tag;
    logic [15:0] p;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wallace_mult_pipe_if #(.WIDTH(W), .TAG_W(TW)) mif ();

  wallace_mult_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_mul (mif)
  );

  vec_t        tbl [12];
  vec_t        bp  [5];
  int          checks = 0;
  int          errors = 0;
  logic [19:0] q [$];
  logic [15:0] cur_exp;
  bit          rnd_or;
  bit          last_in_fire;
  int          send_waits;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
`ifdef WALLACE_SIGNED_EN
    logic signed [15:0] sp;
    sp = $signed(a) * $signed(b);
    return 16'(sp);
`else
    return 16'(a) * 16'(b);
`endif
  endfunction

  // Scoreboard at the falling edge: retire an output beat, then record an accepted input
  task automatic mon_neg();
    logic [19:0] e;
    @(negedge clk);
    last_in_fire = 1'b0;
    if (rst_n) begin
      if (mif.out_valid && mif.out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 32'(mif.out_p), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("beat_p", 32'(mif.out_p), 32'(e[15:0]));
          chk("beat_tag", 32'(mif.out_tag), 32'(e[19:16]));
        end
      end
      if (mif.in_valid && mif.in_ready) begin
        q.push_back({mif.in_tag, cur_exp});
        last_in_fire = 1'b1;
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    if (rnd_or) mif.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic tick();
    mon_neg();
    adv();
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t,
                      input logic [15:0] e);
    bit f;
    mif.in_valid = 1'b1;
    mif.in_a     = a;
    mif.in_b     = b;
    mif.in_tag   = t;
    cur_exp      = e;
    send_waits   = 0;
    for (int k = 0; k < 200; k++) begin
      mon_neg();
      f = last_in_fire;
      adv();
      if (f) begin
        mif.in_valid = 1'b0;
        return;
      end
      send_waits++;
    end
    mif.in_valid = 1'b0;
    chk("send_timeout", 32'(send_waits), 32'd0);
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (q.size() == 0) return;
      tick();
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{8'hFF, 8'hFF, 4'h5, 16'hFE01};
    tbl[1]  = '{8'h80, 8'h80, 4'h1, 16'h4000};
    tbl[2]  = '{8'hFF, 8'h01, 4'h2, 16'h00FF};
    tbl[3]  = '{8'h00, 8'h5A, 4'h3, 16'h0000};
    tbl[4]  = '{8'h12, 8'h34, 4'h4, 16'h03A8};
    tbl[5]  = '{8'h0F, 8'h0F, 4'h6, 16'h00E1};
    tbl[6]  = '{8'hA5, 8'h5A, 4'h7, 16'h3A02};
    tbl[7]  = '{8'h7F, 8'h7F, 4'h8, 16'h3F01};
    tbl[8]  = '{8'h01, 8'h01, 4'h9, 16'h0001};
    tbl[9]  = '{8'h10, 8'h10, 4'hA, 16'h0100};
    tbl[10] = '{8'hC8, 8'h03, 4'hB, 16'h0258};
    tbl[11] = '{8'h64, 8'h64, 4'hC, 16'h2710};
    bp[0]   = '{8'h03, 8'h05, 4'h1, 16'h000F};
    bp[1]   = '{8'h20, 8'h20, 4'h2, 16'h0400};
    bp[2]   = '{8'hFF, 8'h02, 4'h3, 16'h01FE};
    bp[3]   = '{8'h07, 8'h07, 4'h4, 16'h0031};
    bp[4]   = '{8'h40, 8'h03, 4'h6, 16'h00C0};
`ifdef WALLACE_SIGNED_EN
    tbl[0].p  = 16'h0001;
    tbl[2].p  = 16'hFFFF;
    tbl[6].p  = 16'hE002;
    tbl[10].p = 16'hFF58;
    bp[2].p   = 16'hFFFE;
`endif

    mif.in_valid  = 1'b0;
    mif.in_a      = '0;
    mif.in_b      = '0;
    mif.in_tag    = '0;
    mif.out_ready = 1'b1;
    rnd_or        = 1'b0;
    cur_exp       = '0;

    #12;
    chk("rst_out_valid", 32'(mif.out_valid), 32'd0);
    chk("rst_out_p", 32'(mif.out_p), 32'd0);
    chk("rst_out_tag", 32'(mif.out_tag), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_neg();
    chk("rst_in_ready", 32'(mif.in_ready), 32'd1);
    adv();

    // Single op: output valid for exactly one beat, STAGES edges after acceptance
    send(tbl[0].a, tbl[0].b, tbl[0].tag, tbl[0].p);
    for (int k = 0; k <= int'(S); k++) begin
      mon_neg();
      chk("lat_valid", 32'(mif.out_valid), (k == int'(S) - 1) ? 32'd1 : 32'd0);
      adv();
    end

    // Back-to-back table stream with out_ready held high
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].p);
      chk("stream_ready", 32'(send_waits), 32'd0);
    end
    drain();

    // Backpressure: pipeline fills after STAGES accepts and the head result holds
    mif.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(bp[i].a, bp[i].b, bp[i].tag, bp[i].p);
    mon_neg();
    chk("bp_in_ready", 32'(mif.in_ready), 32'd0);
    chk("bp_out_valid", 32'(mif.out_valid), 32'd1);
    adv();
    mif.in_valid = 1'b1;
    mif.in_a     = bp[3].a;
    mif.in_b     = bp[3].b;
    mif.in_tag   = bp[3].tag;
    cur_exp      = bp[3].p;
    for (int k = 0; k < 8; k++) begin
      mon_neg();
      chk("bp_hold_ready", 32'(mif.in_ready), 32'd0);
      chk("bp_hold_p", 32'(mif.out_p), 32'(bp[0].p));
      chk("bp_hold_tag", 32'(mif.out_tag), 32'(bp[0].tag));
      adv();
    end
    mif.out_ready = 1'b1;
    send(bp[3].a, bp[3].b, bp[3].tag, bp[3].p);
    send(bp[4].a, bp[4].b, bp[4].tag, bp[4].p);
    drain();

    // Reset with two ops in flight: output clears at once, nothing stale afterwards
    mif.out_ready = 1'b0;
    send(8'h11, 8'h11, 4'h7, model(8'h11, 8'h11));
    send(8'h22, 8'h02, 4'h8, model(8'h22, 8'h02));
    tick();
    chk("mid_out_valid", 32'(mif.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_valid", 32'(mif.out_valid), 32'd0);
    chk("mid_rst_p", 32'(mif.out_p), 32'd0);
    chk("mid_rst_tag", 32'(mif.out_tag), 32'd0);
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    mif.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      mon_neg();
      chk("post_rst_idle", 32'(mif.out_valid), 32'd0);
      adv();
    end
    send(8'h0D, 8'h0B, 4'h9, 16'h008F);
    drain();

    // Random handshake stream checked in order against the behavioural product
    rnd_or = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      send(ra, rb, 4'(n), model(ra, rb));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end
    rnd_or        = 1'b0;
    mif.out_ready = 1'b1;
    drain();
    tick();
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
